// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program-counter sequencer with IDLE/RUN/DONE run control.
// Optional link register (call/ret) enabled by defining PC_LINK_EN.
module pc_fetch_ctrl #(
  parameter int unsigned   D          = 12,
  parameter logic [D-1:0]  START_ADDR = '0
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         rel_jump,
  input  logic         branch_taken,
  input  logic [D-1:0] target,
  input  logic         abs_jump,
  input  logic [D-1:0] jump_addr,
`ifdef PC_LINK_EN
  input  logic         call,
  input  logic         ret,
  output logic [D-1:0] link_addr,
`endif
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         running_q, running_d;
  logic         done_q, done_d;
  logic [D-1:0] pc_inc, pc_rel;

`ifdef PC_LINK_EN
  logic [D-1:0] link_q, link_d;
`endif

  // Modular adders; carry out is intentionally dropped.
  assign pc_inc = pc_q + D'(1);
  assign pc_rel = pc_q + target;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= START_ADDR;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef PC_LINK_EN
      link_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
`ifdef PC_LINK_EN
      link_q    <= link_d;
`endif
    end
  end

  // Next state and next PC, priority order inside RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_LINK_EN
    link_d  = link_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DONE;
        end else if (!stall) begin
`ifdef PC_LINK_EN
          if (ret) begin
            pc_d = link_q;
          end else if (abs_jump) begin
            pc_d = jump_addr;
          end else if (call) begin
            link_d = pc_inc;
            pc_d   = pc_rel;
          end else if (rel_jump && branch_taken) begin
            pc_d = pc_rel;
          end else begin
            pc_d = pc_inc;
          end
`else
          if (abs_jump) begin
            pc_d = jump_addr;
          end else if (rel_jump && branch_taken) begin
            pc_d = pc_rel;
          end else begin
            pc_d = pc_inc;
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_ADDR;
      end
    endcase
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  assign prog_ctr = pc_q;
  assign running  = running_q;
  assign done     = done_q;
`ifdef PC_LINK_EN
  assign link_addr = link_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus random stimulus vs. a reference model.
module tb_pc_fetch_ctrl;

  localparam int unsigned D   = 12;
  localparam int          MOD = 4096;

  logic         Clk;
  logic         Reset_n;
  logic         start, stall, halt, rel_jump, branch_taken, abs_jump;
  logic [D-1:0] target, jump_addr;
  logic [D-1:0] prog_ctr;
  logic         running, done;
`ifdef PC_LINK_EN
  logic         call, ret;
  logic [D-1:0] link_addr;
`endif

  int total;
  int bad;

  // Reference model: 0 = idle, 1 = run, 2 = done
  int m_state;
  int m_pc;
  int m_link;

  pc_fetch_ctrl #(.D(D), .START_ADDR(12'h000)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .stall        (stall),
    .halt         (halt),
    .rel_jump     (rel_jump),
    .branch_taken (branch_taken),
    .target       (target),
    .abs_jump     (abs_jump),
    .jump_addr    (jump_addr),
`ifdef PC_LINK_EN
    .call         (call),
    .ret          (ret),
    .link_addr    (link_addr),
`endif
    .prog_ctr     (prog_ctr),
    .running      (running),
    .done         (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic clear_inputs();
    start = 0; stall = 0; halt = 0; rel_jump = 0; branch_taken = 0; abs_jump = 0;
    target = '0; jump_addr = '0;
`ifdef PC_LINK_EN
    call = 0; ret = 0;
`endif
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_link = 0;
  endtask

  // Advance the model from the inputs present at the coming edge.
  task automatic model_step();
    if (m_state == 0 || m_state == 2) begin
      if (start) begin m_state = 1; m_pc = 0; end
    end else if (halt) begin
      m_state = 2;
    end else if (!stall) begin
`ifdef PC_LINK_EN
      if (ret) m_pc = m_link;
      else if (abs_jump) m_pc = int'(jump_addr);
      else if (call) begin
        m_link = (m_pc + 1) % MOD;
        m_pc   = (m_pc + int'(target)) % MOD;
      end
      else if (rel_jump && branch_taken) m_pc = (m_pc + int'(target)) % MOD;
      else m_pc = (m_pc + 1) % MOD;
`else
      if (abs_jump) m_pc = int'(jump_addr);
      else if (rel_jump && branch_taken) m_pc = (m_pc + int'(target)) % MOD;
      else m_pc = (m_pc + 1) % MOD;
`endif
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset_n = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if (prog_ctr !== 12'h000 || running !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: pc=%h run=%b done=%b expected pc=000 run=0 done=0", prog_ctr, running, done);
    end
    Reset_n = 1;
    cycle();
    total++;
    if (prog_ctr !== 12'h000 || running !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: pc=%h run=%b expected pc=000 run=0", prog_ctr, running);
    end
  endtask

  task automatic test_start_incr();
    clear_inputs();
    start = 1;
    cycle();
    start = 0;
    total++;
    if (prog_ctr !== 12'h000 || running !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL start: pc=%h run=%b done=%b expected pc=000 run=1 done=0", prog_ctr, running, done);
    end
    repeat (3) cycle();
    total++;
    if (prog_ctr !== 12'h003) begin
      bad++;
      $display("FAIL incr3: pc=%h expected 003", prog_ctr);
    end
    start = 1;
    cycle();
    start = 0;
    total++;
    if (prog_ctr !== 12'h004 || prog_ctr !== 12'(m_pc)) begin
      bad++;
      $display("FAIL start_in_run: pc=%h expected 004", prog_ctr);
    end
  endtask

  task automatic test_rel_branch();
    rel_jump = 1; branch_taken = 1; target = 12'hFFB;
    cycle();
    clear_inputs();
    total++;
    if (prog_ctr !== 12'hFFF) begin
      bad++;
      $display("FAIL rel_neg: pc=%h expected fff", prog_ctr);
    end
    cycle();
    total++;
    if (prog_ctr !== 12'h000) begin
      bad++;
      $display("FAIL wrap: pc=%h expected 000", prog_ctr);
    end
    repeat (4) cycle();
    rel_jump = 1; branch_taken = 0; target = 12'h014;
    cycle();
    total++;
    if (prog_ctr !== 12'h005) begin
      bad++;
      $display("FAIL not_taken: pc=%h expected 005", prog_ctr);
    end
    abs_jump = 0; rel_jump = 0;
    jump_addr = 12'h004; abs_jump = 1;
    cycle();
    abs_jump = 0; rel_jump = 1; branch_taken = 1; target = 12'h014;
    cycle();
    total++;
    if (prog_ctr !== 12'h018) begin
      bad++;
      $display("FAIL taken: pc=%h expected 018", prog_ctr);
    end
    target = 12'h000;
    repeat (2) cycle();
    clear_inputs();
    total++;
    if (prog_ctr !== 12'h018) begin
      bad++;
      $display("FAIL self_loop: pc=%h expected 018", prog_ctr);
    end
  endtask

  task automatic test_stall_abs();
    stall = 1; abs_jump = 1; jump_addr = 12'h100;
    cycle();
    total++;
    if (prog_ctr !== 12'h018) begin
      bad++;
      $display("FAIL stall_hold: pc=%h expected 018", prog_ctr);
    end
    stall = 0;
    cycle();
    clear_inputs();
    total++;
    if (prog_ctr !== 12'h100) begin
      bad++;
      $display("FAIL abs_jump: pc=%h expected 100", prog_ctr);
    end
  endtask

  task automatic test_halt_done();
    abs_jump = 1; jump_addr = 12'h007;
    cycle();
    clear_inputs();
    halt = 1; stall = 1;
    cycle();
    clear_inputs();
    total++;
    if (prog_ctr !== 12'h007 || running !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL halt: pc=%h run=%b done=%b expected pc=007 run=0 done=1", prog_ctr, running, done);
    end
    abs_jump = 1; jump_addr = 12'h155; rel_jump = 1; branch_taken = 1; target = 12'h003;
    repeat (2) cycle();
    clear_inputs();
    total++;
    if (prog_ctr !== 12'h007 || done !== 1'b1) begin
      bad++;
      $display("FAIL done_hold: pc=%h done=%b expected pc=007 done=1", prog_ctr, done);
    end
    start = 1;
    cycle();
    clear_inputs();
    total++;
    if (prog_ctr !== 12'h000 || running !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart: pc=%h run=%b done=%b expected pc=000 run=1 done=0", prog_ctr, running, done);
    end
  endtask

  task automatic test_reset_mid_run();
    repeat (5) cycle();
    Reset_n = 0;
    model_reset();
    #1;
    total++;
    if (prog_ctr !== 12'h000 || running !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: pc=%h run=%b done=%b expected pc=000 run=0 done=0", prog_ctr, running, done);
    end
    @(posedge Clk);
    #1;
    Reset_n = 1;
    cycle();
  endtask

`ifdef PC_LINK_EN
  task automatic test_link();
    clear_inputs();
    start = 1;
    cycle();
    start = 0;
    abs_jump = 1; jump_addr = 12'd10;
    cycle();
    abs_jump = 0;
    stall = 1; call = 1; target = 12'd20;
    cycle();
    stall = 0;
    cycle();
    call = 0;
    total++;
    if (prog_ctr !== 12'd30 || link_addr !== 12'd11) begin
      bad++;
      $display("FAIL call: pc=%0d link=%0d expected pc=30 link=11", prog_ctr, link_addr);
    end
    ret = 1;
    cycle();
    clear_inputs();
    total++;
    if (prog_ctr !== 12'd11) begin
      bad++;
      $display("FAIL ret: pc=%0d expected 11", prog_ctr);
    end
  endtask
`endif

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      start        = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      halt         = ($urandom_range(0, 24) == 0);
      abs_jump     = ($urandom_range(0, 7) == 0);
      rel_jump     = ($urandom_range(0, 2) == 0);
      branch_taken = $urandom_range(0, 1) == 1;
      target       = 12'($urandom);
      jump_addr    = 12'($urandom);
`ifdef PC_LINK_EN
      call         = ($urandom_range(0, 7) == 0);
      ret          = ($urandom_range(0, 9) == 0);
`endif
      cycle();
      total++;
      if (prog_ctr !== 12'(m_pc) || running !== (m_state == 1) || done !== (m_state == 2)) begin
        bad++;
        $display("FAIL random[%0d]: pc=%h run=%b done=%b expected pc=%h run=%b done=%b",
                 i, prog_ctr, running, done, 12'(m_pc), m_state == 1, m_state == 2);
      end
`ifdef PC_LINK_EN
      total++;
      if (link_addr !== 12'(m_link)) begin
        bad++;
        $display("FAIL random_link[%0d]: link=%h expected %h", i, link_addr, 12'(m_link));
      end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset_n = 1;
    test_reset();
    test_start_incr();
    test_rel_branch();
    test_stall_abs();
    test_halt_done();
    test_reset_mid_run();
`ifdef PC_LINK_EN
    test_link();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter sequencer for the fetch stage, directly downstream of the branch-target lookup. Holds the D-bit program counter and each cycle advances it by one, adds the signed relative offset from the target lookup, loads an absolute address, holds, or halts. Its `prog_ctr` output addresses instruction memory. A small run-control FSM starts and ends program execution.

## Interface
- `D`, 12: program-counter width in bits.
- `START_ADDR`, 0: address loaded on `start` and at reset.

- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  begin execution at `START_ADDR`; honoured in IDLE and DONE only.
- `stall`  in  1  hold the PC this cycle.
- `halt`  in  1  the instruction at `prog_ctr` is a halt.
- `rel_jump`  in  1  the instruction at `prog_ctr` is a relative branch.
- `branch_taken`  in  1  branch condition; qualifies `rel_jump`.
- `target`  in  D  two's-complement offset from the target lookup (e.g. 12'hFFB = -5, 12'h014 = +20, 12'hFFF = -1, 0 = hold).
- `abs_jump`  in  1  unconditional absolute jump.
- `jump_addr`  in  D  absolute jump destination.
- `prog_ctr`  out  D  registered program counter.
- `running`  out  1  FSM is in RUN.
- `done`  out  1  FSM is in DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - `start` goes to RUN with `prog_ctr` = `START_ADDR`.
  - All other inputs are ignored.
- RUN: next PC is chosen by priority, highest first:
  - `halt`: go to DONE; PC holds.
  - `stall`: PC holds.
  - `abs_jump`: PC = `jump_addr`.
  - `rel_jump && branch_taken`: PC = (PC + `target`) mod 2^D.
  - Otherwise: PC = (PC + 1) mod 2^D.
- `start` is ignored in RUN.
- DONE:
  - PC holds.
  - `start` goes to RUN with PC = `START_ADDR`.
  - All other inputs are ignored.
- Arithmetic:
  - D-bit modular addition; the carry out is discarded.
  - `target` is applied as is. Its width equals `prog_ctr`, so negative offsets wrap correctly.
  - Examples: 4 + 12'hFFB = 12'hFFF; 12'hFFF + 1 = 0.
- `rel_jump` with `branch_taken`=0 falls through to PC+1.
- `rel_jump` taken with `target`=0 self-loops.
- `halt` with `stall` in the same cycle: `halt` wins.

## Timing
- Reset values: `prog_ctr` = `START_ADDR`, `running` = 0, `done` = 0, state = IDLE. The link register (if present) = 0.
- Reset is asynchronous on assertion; deassertion is synchronous to `Clk` (externally synchronised).
- Reset mid-RUN returns to IDLE immediately. The PC is lost.
- Control inputs are decoded combinationally from the instruction at the current `prog_ctr` and sampled at the rising edge.
- The new `prog_ctr` is visible one cycle later, giving one-cycle latency for every update.
- `running` and `done` are registered and change in the same edge as the state.
- Minimum cycle from `start` in IDLE to the first fetch at `START_ADDR`: one edge. The first fetch is the cycle in which `running`=1.

## Configuration
- `PC_LINK_EN` defined:
  - Adds inputs `call` (1) and `ret` (1), and output `link_addr` (D).
  - In RUN, `call` saves PC+1 (mod 2^D) into `link_addr` and applies PC = PC + `target`, unconditionally.
  - In RUN, `ret` loads PC = `link_addr`.
  - Priority: `halt` > `stall` > `ret` > `abs_jump` > `call` > `rel_jump` > increment.
  - A stalled `call` does not update the link register.
- `PC_LINK_EN` undefined: these ports and the link register are absent; behaviour is as in Operation.

## Test plan
- Reset with `Reset_n`=0, then `start` pulse -> `prog_ctr`=0, `running`=1. After 3 unstalled cycles `prog_ctr`=3.
- At PC=4, `rel_jump`=1, `branch_taken`=1, `target`=12'hFFB -> next PC=12'hFFF. Then plain increment -> 0 (wrap).
- At PC=4, `target`=20 with `branch_taken`=0 -> PC=5. The same with `branch_taken`=1 -> PC=24.
- `stall` together with `abs_jump`, `jump_addr`=12'h100 -> PC holds. Deassert `stall` -> PC=12'h100.
- `halt` at PC=7 -> `done`=1, `running`=0, PC stays 7 under further jumps. `start` -> PC=0, `running`=1. `Reset_n` pulsed mid-RUN -> outputs return to reset values before the next edge.
- (`PC_LINK_EN`) `call` at PC=10 with `target`=20 -> PC=30, `link_addr`=11. `ret` -> PC=11.
